// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard scoreboard: per-stage entry record and slice helper.
package hazard_scoreboard_pkg;

  // Widest register index an entry can hold; RBITS must not exceed this.
  localparam int SB_RD_W = 8;

  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
    logic               we;
    logic               load;
  } sb_entry_t;

  // Bit offset of stage k inside a flat per-stage bus of width w.
  function automatic int stage_slice(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_match_cell.sv
// Priority lookup of one source operand against all tracked stages.
// The youngest (lowest index) matching writer supplies the data.
module sb_match_cell
  import hazard_scoreboard_pkg::*;
#(
  parameter int RBITS      = 4,
  parameter int DBUS       = 32,
  parameter int NSTAGES    = 3,
  parameter int LOAD_STAGE = 1,
  parameter int ZERO_REG   = 0
) (
  input  sb_entry_t [NSTAGES-1:0]   i_ent,
  input  logic [RBITS-1:0]          i_rs,
  input  logic                      i_rs_en,
  input  logic [NSTAGES*DBUS-1:0]   i_stage_data,
  output logic                      o_match,
  output logic [DBUS-1:0]           o_data,
  output logic                      o_load_haz
);

  logic [NSTAGES-1:0] w_hit;
  logic               w_rs_ok;

  // Register 0 never matches when it is the hardwired zero register.
  assign w_rs_ok = i_rs_en && !((ZERO_REG != 0) && (i_rs == '0));

  for (genvar k = 0; k < NSTAGES; k++) begin : g_hit
    assign w_hit[k] = i_ent[k].valid && i_ent[k].we && w_rs_ok &&
                      (i_ent[k].rd == SB_RD_W'(i_rs));
  end

  // Scan oldest to youngest so the youngest hit overwrites the rest.
  always_comb begin
    o_match    = 1'b0;
    o_data     = '0;
    o_load_haz = 1'b0;
    for (int k = NSTAGES - 1; k >= 0; k--) begin
      if (w_hit[k]) begin
        o_match    = 1'b1;
        o_data     = i_stage_data[stage_slice(k, DBUS) +: DBUS];
        o_load_haz = i_ent[k].load && (k < LOAD_STAGE);
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard / forwarding controller: shift register of in-flight writers,
// per-operand forwarding, load-use stall, branch flush, stall counter.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int RBITS      = 4,
  parameter int DBUS       = 32,
  parameter int NSTAGES    = 3,
  parameter int LOAD_STAGE = 1,
  parameter int BR_STAGE   = 1,
  parameter int ZERO_REG   = 0
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_issue_valid,
  input  logic [RBITS-1:0]        i_issue_rd,
  input  logic                    i_issue_we,
  input  logic                    i_issue_load,
  input  logic [RBITS-1:0]        i_issue_rsa,
  input  logic                    i_issue_rsa_en,
  input  logic [RBITS-1:0]        i_issue_rsb,
  input  logic                    i_issue_rsb_en,
  input  logic [NSTAGES*DBUS-1:0] i_stage_data,
  input  logic                    i_branch_taken,
  output logic                    o_fwd_hit_a,
  output logic                    o_fwd_hit_b,
  output logic [DBUS-1:0]         o_fwd_data_a,
  output logic [DBUS-1:0]         o_fwd_data_b,
  output logic                    o_stall,
  output logic                    o_flush,
  output logic [15:0]             o_stall_cnt
);

  sb_entry_t [NSTAGES-1:0] w_ent;
  sb_entry_t               w_new;
  logic                    w_match_a, w_match_b;
  logic                    w_haz_a, w_haz_b;
  logic                    w_stall, w_flush;
  logic [15:0]             r_stall_cnt;

  sb_match_cell #(.RBITS(RBITS), .DBUS(DBUS), .NSTAGES(NSTAGES),
                  .LOAD_STAGE(LOAD_STAGE), .ZERO_REG(ZERO_REG)) u_match_a (
    .i_ent(w_ent), .i_rs(i_issue_rsa), .i_rs_en(i_issue_rsa_en),
    .i_stage_data(i_stage_data), .o_match(w_match_a),
    .o_data(o_fwd_data_a), .o_load_haz(w_haz_a));

  sb_match_cell #(.RBITS(RBITS), .DBUS(DBUS), .NSTAGES(NSTAGES),
                  .LOAD_STAGE(LOAD_STAGE), .ZERO_REG(ZERO_REG)) u_match_b (
    .i_ent(w_ent), .i_rs(i_issue_rsb), .i_rs_en(i_issue_rsb_en),
    .i_stage_data(i_stage_data), .o_match(w_match_b),
    .o_data(o_fwd_data_b), .o_load_haz(w_haz_b));

  assign w_stall     = i_issue_valid && (w_haz_a || w_haz_b);
  assign w_flush     = i_branch_taken && w_ent[BR_STAGE].valid;
  assign o_stall     = w_stall;
  assign o_flush     = w_flush;
  // A stalled instruction must not consume forwarded operands.
  assign o_fwd_hit_a = w_match_a && !w_stall;
  assign o_fwd_hit_b = w_match_b && !w_stall;
  assign o_stall_cnt = r_stall_cnt;

  // Entry entering stage 0: the issued instruction, or a bubble on stall/flush.
  always_comb begin
    w_new = '0;
    if (i_issue_valid && !w_stall && !w_flush) begin
      w_new.valid = 1'b1;
      w_new.rd    = SB_RD_W'(i_issue_rd);
      w_new.we    = i_issue_we;
      w_new.load  = i_issue_load;
    end
  end

  for (genvar g = 0; g < NSTAGES; g++) begin : g_ent
    sb_entry_t r_ent;
    sb_entry_t w_nxt;

    if (g == 0) begin : g_head
      assign w_nxt = w_new;
    end else begin : g_shift
      // Shift from the younger stage; flush kills anything younger than the branch.
      always_comb begin
        w_nxt = w_ent[g-1];
        if (w_flush && ((g - 1) < BR_STAGE)) w_nxt.valid = 1'b0;
      end
    end

    // Stage register advances every cycle; downstream never freezes.
    always_ff @(posedge i_clk) begin
      if (i_rst) r_ent <= '0;
      else       r_ent <= w_nxt;
    end

    assign w_ent[g] = r_ent;
  end

  // Saturating count of cycles lost to load-use stalls (flush takes precedence).
  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_stall_cnt <= '0;
    else if (w_stall && !w_flush && (r_stall_cnt != 16'hFFFF))
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus random traffic checked
// against an age-based model of in-flight instructions; a second deep instance
// exercises stall counter saturation.
module tb_hazard_scoreboard;

  localparam int RB = 4, DB = 32, NS = 3, LS = 1, BS = 1;
  localparam int SNS = 32, SLS = 31;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              iv, we, ld, a_en, b_en, br;
  logic [RB-1:0]     rd, rsa, rsb;
  logic [NS*DB-1:0]  sdata;
  logic              hit_a, hit_b, stall, flush;
  logic [DB-1:0]     data_a, data_b;
  logic [15:0]       cnt;

  logic              s_iv;
  logic [SNS*DB-1:0] s_sdata;
  logic              s_hit_a, s_hit_b, s_stall, s_flush;
  logic [DB-1:0]     s_data_a, s_data_b;
  logic [15:0]       s_cnt;

  int n_chk = 0, n_err = 0;

  hazard_scoreboard #(.RBITS(RB), .DBUS(DB), .NSTAGES(NS), .LOAD_STAGE(LS),
                      .BR_STAGE(BS), .ZERO_REG(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_issue_valid(iv), .i_issue_rd(rd),
    .i_issue_we(we), .i_issue_load(ld), .i_issue_rsa(rsa), .i_issue_rsa_en(a_en),
    .i_issue_rsb(rsb), .i_issue_rsb_en(b_en), .i_stage_data(sdata),
    .i_branch_taken(br), .o_fwd_hit_a(hit_a), .o_fwd_hit_b(hit_b),
    .o_fwd_data_a(data_a), .o_fwd_data_b(data_b), .o_stall(stall),
    .o_flush(flush), .o_stall_cnt(cnt));

  // Deep-load instance: a self-dependent load chain stalls 31 of every 32 cycles.
  hazard_scoreboard #(.RBITS(RB), .DBUS(DB), .NSTAGES(SNS), .LOAD_STAGE(SLS),
                      .BR_STAGE(1), .ZERO_REG(0)) dut_sat (
    .i_clk(clk), .i_rst(rst), .i_issue_valid(s_iv), .i_issue_rd(4'd1),
    .i_issue_we(1'b1), .i_issue_load(1'b1), .i_issue_rsa(4'd1), .i_issue_rsa_en(1'b1),
    .i_issue_rsb(4'd0), .i_issue_rsb_en(1'b0), .i_stage_data(s_sdata),
    .i_branch_taken(1'b0), .o_fwd_hit_a(s_hit_a), .o_fwd_hit_b(s_hit_b),
    .o_fwd_data_a(s_data_a), .o_fwd_data_b(s_data_b), .o_stall(s_stall),
    .o_flush(s_flush), .o_stall_cnt(s_cnt));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Model: list of in-flight instructions, youngest first, each with its age
  // in cycles since issue (age == stage index).
  typedef struct {
    logic [RB-1:0] rd;
    logic          we;
    logic          ld;
    int            age;
  } rec_t;
  rec_t q[$];
  int   m_cnt = 0;

  task automatic lookup(input logic [RB-1:0] rs, input logic en,
                        output logic hit, output int age, output logic lflag);
    hit = 1'b0; age = 0; lflag = 1'b0;
    if (en && rs != 0)
      foreach (q[i])
        if (!hit && q[i].we && q[i].rd == rs) begin
          hit = 1'b1; age = q[i].age; lflag = q[i].ld;
        end
  endtask

  // Check all outputs at the negedge against the model, then advance one cycle.
  task automatic tick();
    logic ha, hb, la, lb, st_e, fl_e;
    int   aa, ab;
    rec_t nq[$];
    @(negedge clk);
    lookup(rsa, a_en, ha, aa, la);
    lookup(rsb, b_en, hb, ab, lb);
    st_e = iv && ((ha && la && aa < LS) || (hb && lb && ab < LS));
    fl_e = 1'b0;
    foreach (q[i]) if (q[i].age == BS) fl_e = br;
    chk("stall", stall, st_e);
    chk("flush", flush, fl_e);
    chk("hit_a", hit_a, ha && !st_e);
    chk("hit_b", hit_b, hb && !st_e);
    chk("data_a", data_a, ha ? sdata[aa*DB +: DB] : 32'h0);
    chk("data_b", data_b, hb ? sdata[ab*DB +: DB] : 32'h0);
    chk("stall_cnt", cnt, m_cnt);
    if (rst) begin
      q.delete();
      m_cnt = 0;
    end else begin
      foreach (q[i]) begin
        rec_t r;
        r = q[i];
        if (fl_e && r.age < BS) continue;
        r.age++;
        if (r.age < NS) nq.push_back(r);
      end
      if (iv && !st_e && !fl_e) nq.push_front('{rd: rd, we: we, ld: ld, age: 0});
      q = nq;
      if (st_e && !fl_e && m_cnt < 65535) m_cnt++;
    end
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic v, input logic [RB-1:0] d, input logic w, input logic l,
                       input logic [RB-1:0] a, input logic ae,
                       input logic [RB-1:0] b, input logic be);
    iv = v; rd = d; we = w; ld = l; rsa = a; a_en = ae; rsb = b; b_en = be;
  endtask

  task automatic idle(input int n);
    issue(0, 0, 0, 0, 0, 0, 0, 0);
    br = 0;
    repeat (n) tick();
  endtask

  initial begin
    int c0;
    rst = 1; br = 0; sdata = '0; s_iv = 0; s_sdata = '0;
    issue(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); @(posedge clk); #1;
    // Reset state, checked with reset still held.
    chk("rst_stall_cnt", cnt, 16'h0);
    tick();
    rst = 0;

    // Forward from stage 0.
    issue(1, 3, 1, 0, 1, 1, 2, 1); tick();
    issue(1, 4, 1, 0, 3, 1, 0, 0); sdata = '0; sdata[31:0] = 32'h11; #1;
    chk("t1_hit_a", hit_a, 1); chk("t1_data_a", data_a, 32'h11); chk("t1_stall", stall, 0);
    tick();

    // Load-use: one stall, then forward from stage 1.
    idle(3);
    issue(1, 2, 1, 1, 0, 0, 0, 0); tick();
    issue(1, 5, 1, 0, 2, 1, 0, 0); sdata[63:32] = 32'hDEAD_BEEF; #1;
    chk("t2_stall", stall, 1); chk("t2_hit_a_stalled", hit_a, 0);
    tick();
    chk("t2_cnt", cnt, 16'd1);
    chk("t2_stall_clear", stall, 0); chk("t2_hit_a", hit_a, 1);
    chk("t2_data_a", data_a, 32'hDEAD_BEEF);
    tick();

    // Youngest writer wins.
    idle(3);
    issue(1, 7, 1, 0, 0, 0, 0, 0); tick();
    issue(1, 1, 1, 0, 0, 0, 0, 0); tick();
    issue(1, 7, 1, 0, 0, 0, 0, 0); tick();
    issue(1, 8, 1, 0, 0, 0, 7, 1); sdata = '0; sdata[31:0] = 32'hA; sdata[95:64] = 32'hB; #1;
    chk("t3_data_b", data_b, 32'hA);
    tick();

    // Branch in stage 1 flushes stage 0 and the issuing instruction.
    idle(3);
    issue(1, 9, 1, 0, 0, 0, 0, 0); tick();
    issue(1, 6, 1, 0, 0, 0, 0, 0); tick();
    issue(1, 8, 1, 0, 0, 0, 0, 0); br = 1; #1;
    chk("t4_flush", flush, 1);
    tick();
    issue(1, 10, 1, 0, 6, 1, 9, 1); sdata = '0; sdata[95:64] = 32'h99; #1;
    chk("t4_flush_after", flush, 0); chk("t4_hit_a_killed", hit_a, 0);
    chk("t4_hit_b_br_s2", hit_b, 1); chk("t4_data_b", data_b, 32'h99);
    br = 0;
    tick();

    // Zero register never forwards; reset forgets in-flight hazards.
    idle(3);
    issue(1, 0, 1, 0, 0, 0, 0, 0); tick();
    issue(1, 1, 1, 0, 0, 1, 0, 0); #1;
    chk("t5_zero_hit", hit_a, 0);
    tick();
    issue(1, 3, 1, 0, 0, 0, 0, 0); tick();
    issue(1, 2, 1, 1, 0, 0, 0, 0); tick();
    issue(1, 4, 1, 0, 2, 1, 3, 1); rst = 1; tick();
    rst = 0; #1;
    chk("t5_rst_hit_a", hit_a, 0); chk("t5_rst_hit_b", hit_b, 0); chk("t5_rst_stall", stall, 0);
    tick();

    // Stall and flush together: flush wins, counter holds.
    idle(3);
    issue(1, 1, 0, 0, 0, 0, 0, 0); tick();
    issue(1, 2, 1, 1, 0, 0, 0, 0); tick();
    issue(1, 5, 1, 0, 2, 1, 0, 0); br = 1; c0 = m_cnt; #1;
    chk("t6_stall", stall, 1); chk("t6_flush", flush, 1);
    tick();
    chk("t6_cnt_held", cnt, c0);
    br = 0;
    idle(3);

    // Random traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      issue($urandom_range(0, 3) != 0, RB'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, RB'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
            RB'($urandom_range(0, 3)), $urandom_range(0, 1) != 0);
      br = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < NS; k++) sdata[k*DB +: DB] = $urandom;
      tick();
    end
    rst = 0;
    idle(3);

    // Saturation on the deep instance.
    s_iv = 1;
    repeat (320) @(posedge clk);
    #1;
    chk("sat_cnt_320", s_cnt, 16'd310);
    repeat (72680) @(posedge clk);
    #1;
    chk("sat_cnt_max", s_cnt, 16'hFFFF);
    repeat (100) @(posedge clk);
    #1;
    chk("sat_cnt_hold", s_cnt, 16'hFFFF);
    s_iv = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
